// File: rtl/line_fill_ctrl_pkg.sv
// Shared types and widths for the line fill controller.
// Optional critical-word-first bursts: LINE_FILL_CWF_EN.
package line_fill_ctrl_pkg;

  localparam int LINE_W = 5;
  localparam int WORD_W = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = LINE_W + WORD_W;
  localparam int NLINES = 1 << LINE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/line_fill_ctrl_if.sv
// SDRAM burst bus between the fill controller and memory side.
// Master issues the burst request, slave acks and streams words.
interface line_fill_ctrl_if;
  import line_fill_ctrl_pkg::*;

  logic              sd_req;
  logic [ADDR_W-1:0] sd_addr;
  logic              sd_ack;
  logic              sd_dv;
  logic [DATA_W-1:0] sd_data;

  modport master (
    output sd_req, sd_addr,
    input  sd_ack, sd_dv, sd_data
  );

  modport slave (
    input  sd_req, sd_addr,
    output sd_ack, sd_dv, sd_data
  );

endinterface

// File: rtl/tpram_128x32.sv
// Two-port 128x32 line store: one write port, one registered read port.
// Read-before-write on same-address collisions.
module tpram_128x32
  import line_fill_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_fill_ctrl.sv
// Line fill controller: fetches 4-word lines over an SDRAM burst bus.
// LINE_FILL_CWF_EN selects critical-word-first burst order.
module line_fill_ctrl
  import line_fill_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              fill_req,
  input  logic [LINE_W-1:0] fill_line,
  input  logic [WORD_W-1:0] fill_word,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fill_err,
  input  logic              inv_all,
  line_fill_ctrl_if.master  sd,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic              rd_miss,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t            state;
  logic [LINE_W-1:0] line;
  logic [WORD_W-1:0] start;
  logic [WORD_W-1:0] cnt;
  logic [7:0]        tmo;
  logic [NLINES-1:0] valid;
  logic [WORD_W-1:0] fword;
  logic [WORD_W-1:0] wword;
  logic              we;

`ifdef LINE_FILL_CWF_EN
  assign fword = fill_word;
`else
  logic unused_fill_word;
  assign unused_fill_word = ^fill_word;
  assign fword = '0;
`endif

  // burst words wrap within the line
  assign wword = start + cnt;
  assign we    = (state == S_DATA) && sd.sd_dv;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      line       <= '0;
      start      <= '0;
      cnt        <= '0;
      tmo        <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
      sd.sd_req  <= 1'b0;
      sd.sd_addr <= '0;
    end else begin
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fill_req) begin
            line       <= fill_line;
            start      <= fword;
            cnt        <= '0;
            tmo        <= '0;
            fill_busy  <= 1'b1;
            sd.sd_req  <= 1'b1;
            sd.sd_addr <= {fill_line, fword};
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (sd.sd_ack) begin
            sd.sd_req <= 1'b0;
            state     <= S_DATA;
          end else if (tmo == TMO_LAST) begin
            sd.sd_req <= 1'b0;
            fill_err  <= 1'b1;
            state     <= S_ERR;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        S_DATA: begin
          if (sd.sd_dv) begin
            cnt <= cnt + 1'b1;
            if (cnt == 2'd3) begin
              fill_done <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE, S_ERR: begin
          fill_busy <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // inv_all outranks the DONE-cycle set
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      valid <= '0;
    else if (inv_all)
      valid <= '0;
    else if (state == S_IDLE && fill_req)
      valid[fill_line] <= 1'b0;
    else if (state == S_DONE)
      valid[line] <= 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_hit  <= 1'b0;
      rd_miss <= 1'b0;
    end else begin
      rd_hit  <= rd_req &&  valid[rd_addr[ADDR_W-1:WORD_W]];
      rd_miss <= rd_req && !valid[rd_addr[ADDR_W-1:WORD_W]];
    end
  end

  tpram_128x32 u_ram (
    .clock (clock),
    .rst_n (rst_n),
    .we    (we),
    .waddr ({line, wword}),
    .wdata (sd.sd_data),
    .re    (rd_req),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl; honours LINE_FILL_CWF_EN.
module tb_line_fill_ctrl;
  import line_fill_ctrl_pkg::*;

`ifdef LINE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        fill_req = 1'b0;
  logic [4:0]  fill_line = '0;
  logic [1:0]  fill_word = '0;
  logic        fill_busy, fill_done, fill_err;
  logic        inv_all = 1'b0;
  logic        rd_req = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic        rd_hit, rd_miss;
  logic [31:0] rd_data;

  int vecs = 0;
  int errs = 0;

  line_fill_ctrl_if sd_bus ();

  line_fill_ctrl #(.ACK_TIMEOUT(255)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .fill_req  (fill_req),
    .fill_line (fill_line),
    .fill_word (fill_word),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .fill_err  (fill_err),
    .inv_all   (inv_all),
    .sd        (sd_bus),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_miss   (rd_miss),
    .rd_data   (rd_data)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] exp_start(input logic [1:0] w);
    return CWF ? w : 2'd0;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] base,
                                           input logic [1:0] w,
                                           input logic [1:0] st);
    logic [1:0] k;
    k = w - st;
    return base + 32'(k);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_fill(input logic [4:0] l, input logic [1:0] w);
    fill_line = l;
    fill_word = w;
    fill_req  = 1'b1;
    tick();
    fill_req  = 1'b0;
  endtask

  task automatic give_ack(input int dly);
    repeat (dly) tick();
    sd_bus.sd_ack = 1'b1;
    tick();
    sd_bus.sd_ack = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    repeat (gap) tick();
    sd_bus.sd_dv   = 1'b1;
    sd_bus.sd_data = d;
    tick();
    sd_bus.sd_dv   = 1'b0;
    sd_bus.sd_data = 32'hDEAD_BEEF;
  endtask

  task automatic do_read(input logic [6:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sd_bus.sd_ack  = 1'b0;
    sd_bus.sd_dv   = 1'b0;
    sd_bus.sd_data = '0;
    repeat (3) tick();
    vecs++;
    if ({fill_busy, fill_done, fill_err, sd_bus.sd_req, rd_hit, rd_miss} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 000000",
               {fill_busy, fill_done, fill_err, sd_bus.sd_req, rd_hit, rd_miss});
    end
    vecs++;
    if (sd_bus.sd_addr !== 7'h00 || rd_data !== 32'h0) begin
      errs++;
      $display("FAIL reset_buses got addr=%h data=%h want 00/0",
               sd_bus.sd_addr, rd_data);
    end
    rst_n = 1'b1;
    tick();
    do_read(7'h00);
    vecs++;
    if (rd_hit !== 1'b0 || rd_miss !== 1'b1) begin
      errs++;
      $display("FAIL reset_rd_miss got hit=%b miss=%b want 0/1", rd_hit, rd_miss);
    end
  endtask

  task automatic test_fill();
    logic [1:0] st;
    st = exp_start(2'd2);
    start_fill(5'd3, 2'd2);
    vecs++;
    if (sd_bus.sd_req !== 1'b1 || sd_bus.sd_addr !== {5'd3, st} || fill_busy !== 1'b1) begin
      errs++;
      $display("FAIL fill_req got req=%b addr=%h busy=%b want 1/%h/1",
               sd_bus.sd_req, sd_bus.sd_addr, fill_busy, {5'd3, st});
    end
    repeat (5) tick();
    vecs++;
    if (sd_bus.sd_req !== 1'b1) begin
      errs++;
      $display("FAIL sd_req_hold got %b want 1", sd_bus.sd_req);
    end
    give_ack(0);
    vecs++;
    if (sd_bus.sd_req !== 1'b0) begin
      errs++;
      $display("FAIL sd_req_drop got %b want 0", sd_bus.sd_req);
    end
    for (int i = 0; i < 4; i++)
      send_word(32'hA0 + 32'(i), (i == 1) ? 2 : 0);
    vecs++;
    if (fill_done !== 1'b1) begin
      errs++;
      $display("FAIL fill_done_pulse got %b want 1", fill_done);
    end
    tick();
    vecs++;
    if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
      errs++;
      $display("FAIL fill_done_end got done=%b busy=%b want 0/0", fill_done, fill_busy);
    end
    for (int w = 0; w < 4; w++) begin
      do_read({5'd3, 2'(w)});
      vecs++;
      if (rd_hit !== 1'b1 || rd_miss !== 1'b0 ||
          rd_data !== exp_word(32'hA0, 2'(w), st)) begin
        errs++;
        $display("FAIL fill_rd_w%0d got hit=%b miss=%b data=%h want 1/0/%h",
                 w, rd_hit, rd_miss, rd_data, exp_word(32'hA0, 2'(w), st));
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    start_fill(5'd3, 2'd1);
    for (int c = 0; c < 400; c++) begin
      tick();
      n++;
      if (fill_err === 1'b1) break;
    end
    vecs++;
    if (fill_err !== 1'b1 || n != 255) begin
      errs++;
      $display("FAIL timeout_err got err=%b after %0d cycles want 1 after 255",
               fill_err, n);
    end
    tick();
    vecs++;
    if (fill_err !== 1'b0 || fill_busy !== 1'b0 || sd_bus.sd_req !== 1'b0) begin
      errs++;
      $display("FAIL timeout_end got err=%b busy=%b req=%b want 0/0/0",
               fill_err, fill_busy, sd_bus.sd_req);
    end
    do_read(7'h0C);
    vecs++;
    if (rd_hit !== 1'b0 || rd_miss !== 1'b1) begin
      errs++;
      $display("FAIL timeout_rd got hit=%b miss=%b want 0/1", rd_hit, rd_miss);
    end
  endtask

  task automatic test_read_during_fill();
    start_fill(5'd5, 2'd0);
    give_ack(1);
    send_word(32'hB0, 0);
    send_word(32'hB1, 0);
    do_read(7'h14);
    vecs++;
    if (rd_hit !== 1'b0 || rd_miss !== 1'b1) begin
      errs++;
      $display("FAIL during_fill_rd got hit=%b miss=%b want 0/1", rd_hit, rd_miss);
    end
    send_word(32'hB2, 3);
    send_word(32'hB3, 0);
    vecs++;
    if (fill_done !== 1'b1) begin
      errs++;
      $display("FAIL during_fill_done got %b want 1", fill_done);
    end
    tick();
    do_read(7'h14);
    vecs++;
    if (rd_hit !== 1'b1 || rd_miss !== 1'b0 || rd_data !== 32'hB0) begin
      errs++;
      $display("FAIL after_fill_rd got hit=%b miss=%b data=%h want 1/0/b0",
               rd_hit, rd_miss, rd_data);
    end
  endtask

  task automatic test_inv_at_done();
    start_fill(5'd9, 2'd3);
    give_ack(0);
    for (int i = 0; i < 4; i++)
      send_word(32'hC0 + 32'(i), 0);
    vecs++;
    if (fill_done !== 1'b1) begin
      errs++;
      $display("FAIL inv_done_pulse got %b want 1", fill_done);
    end
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    vecs++;
    if (fill_done !== 1'b0) begin
      errs++;
      $display("FAIL inv_done_len got %b want 0", fill_done);
    end
    do_read({5'd9, 2'd0});
    vecs++;
    if (rd_hit !== 1'b0 || rd_miss !== 1'b1) begin
      errs++;
      $display("FAIL inv_rd_l9 got hit=%b miss=%b want 0/1", rd_hit, rd_miss);
    end
    do_read({5'd5, 2'd0});
    vecs++;
    if (rd_hit !== 1'b0 || rd_miss !== 1'b1) begin
      errs++;
      $display("FAIL inv_rd_l5 got hit=%b miss=%b want 0/1", rd_hit, rd_miss);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] st10, st11;
    st10 = exp_start(2'd1);
    st11 = exp_start(2'd2);
    start_fill(5'd10, 2'd1);
    give_ack(2);
    for (int i = 0; i < 4; i++)
      send_word(32'hD0 + 32'(i), 0);
    tick();
    start_fill(5'd11, 2'd2);
    vecs++;
    if (sd_bus.sd_req !== 1'b1 || sd_bus.sd_addr !== {5'd11, st11}) begin
      errs++;
      $display("FAIL b2b_accept got req=%b addr=%h want 1/%h",
               sd_bus.sd_req, sd_bus.sd_addr, {5'd11, st11});
    end
    start_fill(5'd20, 2'd3);
    vecs++;
    if (sd_bus.sd_addr !== {5'd11, st11} || sd_bus.sd_req !== 1'b1) begin
      errs++;
      $display("FAIL busy_ignore got req=%b addr=%h want 1/%h",
               sd_bus.sd_req, sd_bus.sd_addr, {5'd11, st11});
    end
    give_ack(0);
    for (int i = 0; i < 4; i++)
      send_word(32'hE0 + 32'(i), 0);
    tick();
    sd_bus.sd_dv   = 1'b1;
    sd_bus.sd_data = 32'hFFFF_FFFF;
    tick();
    sd_bus.sd_dv   = 1'b0;
    do_read({5'd11, st11});
    vecs++;
    if (rd_hit !== 1'b1 || rd_data !== 32'hE0) begin
      errs++;
      $display("FAIL stray_dv got hit=%b data=%h want 1/e0", rd_hit, rd_data);
    end
    do_read({5'd10, 2'd1});
    vecs++;
    if (rd_hit !== 1'b1 || rd_data !== exp_word(32'hD0, 2'd1, st10)) begin
      errs++;
      $display("FAIL b2b_rd_l10 got hit=%b data=%h want 1/%h",
               rd_hit, rd_data, exp_word(32'hD0, 2'd1, st10));
    end
    do_read({5'd20, 2'd0});
    vecs++;
    if (rd_hit !== 1'b0 || rd_miss !== 1'b1) begin
      errs++;
      $display("FAIL busy_ignore_rd got hit=%b miss=%b want 0/1", rd_hit, rd_miss);
    end
  endtask

  task automatic test_reset_mid_fill();
    start_fill(5'd12, 2'd0);
    give_ack(0);
    send_word(32'hF0, 0);
    send_word(32'hF1, 0);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({fill_busy, fill_done, fill_err, sd_bus.sd_req, rd_hit, rd_miss} !== 6'b0 ||
        sd_bus.sd_addr !== 7'h00 || rd_data !== 32'h0) begin
      errs++;
      $display("FAIL mid_reset got flags=%b addr=%h data=%h want 0/00/0",
               {fill_busy, fill_done, fill_err, sd_bus.sd_req, rd_hit, rd_miss},
               sd_bus.sd_addr, rd_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_read({5'd11, 2'd0});
    vecs++;
    if (rd_hit !== 1'b0 || rd_miss !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset_inval got hit=%b miss=%b want 0/1", rd_hit, rd_miss);
    end
    start_fill(5'd12, 2'd0);
    give_ack(1);
    for (int i = 0; i < 4; i++)
      send_word(32'h10 + 32'(i), 1);
    vecs++;
    if (fill_done !== 1'b1) begin
      errs++;
      $display("FAIL refill_done got %b want 1", fill_done);
    end
    tick();
    do_read({5'd12, 2'd3});
    vecs++;
    if (rd_hit !== 1'b1 || rd_miss !== 1'b0 || rd_data !== 32'h13) begin
      errs++;
      $display("FAIL refill_rd got hit=%b miss=%b data=%h want 1/0/13",
               rd_hit, rd_miss, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_timeout();
    test_read_during_fill();
    test_inv_at_done();
    test_back_to_back();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
